bus_arbiter: RTL and testbench

- Shares the single data-bus slave port (DRAM/peripheral bridge) between two masters: m0 = CPU load/store path, m1 = DMA/loader engine.
- Round-robin arbitration, one outstanding transaction at a time, with registered request capture toward the slave and a one-cycle done pulse back to the winning master.
- Sits between the masters' bus outputs and the bridge; the CPU stalls while m0_req is high and m0_done is low.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_rr_pick.sv | 27 ++
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared encodings for the two-master bus arbiter.
//   arb_state_e   : FSM state encoding (IDLE / XFER / DONE).
//   ARB_M0/ARB_M1 : owner / grant identifiers.
//   ARB_ERR_RDATA : read data returned on a timed-out transfer (32-bit build).
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam logic [31:0] ARB_ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// arb_rr_pick: combinational two-way round-robin pick.
//   m0_req, m1_req : pending requests
//   rr_last        : master granted most recently
//   grant_valid    : at least one request pending
//   grant_id       : winner (ARB_M0 / ARB_M1); on a tie the master that
//                    was not granted last wins.
module arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic rr_last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req)
            grant_id = ~rr_last;
        else if (m1_req)
            grant_id = ARB_M1;
        else
            grant_id = ARB_M0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one slave bus port between two masters (m0 = CPU,
// m1 = DMA) with round-robin arbitration, one transaction in flight.
//   cpu_clk / cpu_rst          : clock, asynchronous active-low reset
//   m{0,1}_req/addr/we/wdata   : master requests (req held until done)
//   m{0,1}_done/rdata          : one-cycle completion pulse + read data
//   s_req/addr/we/wdata        : registered slave request, held until s_ack
//   s_ack / s_rdata            : slave completion and read data
//   owner                      : currently granted master
//   bus_err                    : pulses with done when a transfer timed out
// Optional feature: define BUS_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC cycles without s_ack; otherwise XFER waits indefinitely.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              bus_err
);

    arb_state_e state, next_state;
    logic       rr_last;
    logic       grant_valid;
    logic       grant_id;
    logic       timeout;

    arb_rr_pick u_pick (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .rr_last     (rr_last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] to_cnt;

    // Counts XFER cycles without s_ack; the cycle holding TIMEOUT_CYC-1
    // is the last one, so a full transfer window is TIMEOUT_CYC cycles.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst)
            to_cnt <= '0;
        else if (state != ARB_XFER)
            to_cnt <= '0;
        else if (!s_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    // s_ack takes priority over a coincident timeout.
    assign timeout = (state == ARB_XFER) && !s_ack &&
                     (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst)
            state <= ARB_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (grant_valid) next_state = ARB_XFER;
            ARB_XFER: if (s_ack || timeout) next_state = ARB_DONE;
            ARB_DONE: next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    // Datapath: request capture, completion and read-data return.
    // done/bus_err are set on the completing edge so they are high
    // exactly for the DONE cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            s_req    <= 1'b0;
            s_addr   <= '0;
            s_we     <= 1'b0;
            s_wdata  <= '0;
            owner    <= ARB_M0;
            rr_last  <= ARB_M1;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            bus_err  <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        s_req   <= 1'b1;
                        s_addr  <= (grant_id == ARB_M1) ? m1_addr  : m0_addr;
                        s_we    <= (grant_id == ARB_M1) ? m1_we    : m0_we;
                        s_wdata <= (grant_id == ARB_M1) ? m1_wdata : m0_wdata;
                        owner   <= grant_id;
                        rr_last <= grant_id;
                    end
                end
                ARB_XFER: begin
                    if (s_ack) begin
                        s_req <= 1'b0;
                        if (owner == ARB_M1) begin
                            m1_done <= 1'b1;
                            if (!s_we) m1_rdata <= s_rdata;
                        end else begin
                            m0_done <= 1'b1;
                            if (!s_we) m0_rdata <= s_rdata;
                        end
                    end else if (timeout) begin
                        s_req   <= 1'b0;
                        bus_err <= 1'b1;
                        if (owner == ARB_M1) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= {DATA_W{1'b1}};
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= {DATA_W{1'b1}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        cpu_clk, cpu_rst;
    logic        m0_req, m0_we, m0_done;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_done;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        owner, bus_err;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner), .bus_err(bus_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: acks after ack_wait wait cycles while enabled.
    // Read data is either fixed_rdata or {addr[15:0], 16'hBEEF}.
    logic        slave_en    = 1'b0;
    logic        use_fixed   = 1'b0;
    logic        force_ack   = 1'b0;
    logic [31:0] fixed_rdata = '0;
    int          ack_wait    = 0;
    int          wcnt        = 0;

    initial begin
        s_ack   = 1'b0;
        s_rdata = '0;
    end

    always @(negedge cpu_clk) begin
        if (s_req && slave_en) begin
            if (wcnt == ack_wait) begin
                s_ack   = 1'b1;
                s_rdata = use_fixed ? fixed_rdata : {s_addr[15:0], 16'hBEEF};
                wcnt    = 0;
            end else begin
                s_ack = force_ack;
                wcnt++;
            end
        end else begin
            s_ack = force_ack;
            wcnt  = 0;
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge cpu_clk) begin
        if (cpu_rst && (m0_done || m1_done)) begin
            if (m0_done && m1_done) check("both_done", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_id", {31'd0, m1_done}, {31'd0, e.id});
                check("owner", {31'd0, owner}, {31'd0, e.id});
                check("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
                check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    function automatic exp_t mk(input logic id, input logic [31:0] rd, input logic err);
        exp_t e;
        e.id = id; e.rdata = rd; e.err = err;
        return e;
    endfunction

    // Counts negedges after the current posedge until a done pulse;
    // the granting master's req is dropped when its done is seen.
    task automatic wait_done(input int limit, output int at, output int sreq_n);
        at = -1;
        sreq_n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge cpu_clk);
            if (s_req) sreq_n++;
            if (m0_done || m1_done) begin
                at = i;
                if (m0_done) m0_req = 1'b0;
                if (m1_done) m1_req = 1'b0;
                break;
            end
        end
        if (at < 0) check("done_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        cpu_rst = 1'b0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
    endtask

    int          at, hi, errs, ndone;
    logic [31:0] m0_exp;

    initial begin
        cpu_rst = 1'b0;
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0;

        // Reset state
        repeat (3) @(negedge cpu_clk);
        check("rst_s_req",   {31'd0, s_req},   32'd0);
        check("rst_m0_done", {31'd0, m0_done}, 32'd0);
        check("rst_m1_done", {31'd0, m1_done}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_owner",   {31'd0, owner},   32'd0);
        check("rst_s_addr",  s_addr,   32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        cpu_rst = 1'b1;
        @(posedge cpu_clk); #1;

        // 1: single m0 read, zero-wait ack
        slave_en = 1; use_fixed = 1; fixed_rdata = 32'h1234_5678; ack_wait = 0;
        m0_req = 1; m0_addr = 32'h0000_1000; m0_we = 0;
        exp_q.push_back(mk(1'b0, 32'h1234_5678, 1'b0));
        @(posedge cpu_clk);
        wait_done(10, at, hi);
        check("t1_done_latency", at, 32'd2);
        check("t1_s_req_cycles", hi, 32'd1);

        // 2: simultaneous requests from reset, alternating grants
        @(posedge cpu_clk); #1;
        do_reset();
        use_fixed = 0;
        m0_req = 1; m0_addr = 32'h0000_0100; m0_we = 0;
        m1_req = 1; m1_addr = 32'h0000_0200; m1_we = 0;
        exp_q.push_back(mk(1'b0, 32'h0100_BEEF, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0200_BEEF, 1'b0));
        exp_q.push_back(mk(1'b0, 32'h0100_BEEF, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0200_BEEF, 1'b0));
        @(posedge cpu_clk);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge cpu_clk);
            if (m0_done || m1_done) ndone++;
            if (ndone == 4) begin
                m0_req = 0; m1_req = 0;
                break;
            end
        end
        check("t2_done_count", ndone, 32'd4);

        // 3: m1 write with 3 wait states; inputs change after grant
        @(posedge cpu_clk); #1;
        ack_wait = 3;
        m1_req = 1; m1_addr = 32'h8000_0010; m1_we = 1; m1_wdata = 32'hCAFE_F00D;
        exp_q.push_back(mk(1'b1, 32'h0200_BEEF, 1'b0));
        @(posedge cpu_clk);
        hi = 0; at = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge cpu_clk);
            if (s_req) begin
                hi++;
                check("t3_s_addr",  s_addr,  32'h8000_0010);
                check("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
                check("t3_s_we",    {31'd0, s_we}, 32'd1);
                m1_addr = 32'hDEAD_0000; m1_wdata = 32'h0;
            end
            if (m1_done) begin
                at = i; m1_req = 0; m1_we = 0;
                break;
            end
        end
        check("t3_s_req_cycles", hi, 32'd4);
        check("t3_done_latency", at, 32'd5);

        // 4: reset mid-XFER, then pending m0 re-granted
        @(posedge cpu_clk); #1;
        slave_en = 0; ack_wait = 0; use_fixed = 1; fixed_rdata = 32'hA0A0_0001;
        m0_req = 1; m0_addr = 32'h0000_0040; m0_we = 0;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("t4_s_req_before", {31'd0, s_req}, 32'd1);
        #2 cpu_rst = 1'b0;
        #1;
        check("t4_s_req_async", {31'd0, s_req}, 32'd0);
        check("t4_no_done", {30'd0, m1_done, m0_done}, 32'd0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        slave_en = 1;
        exp_q.push_back(mk(1'b0, 32'hA0A0_0001, 1'b0));
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        wait_done(10, at, hi);
        check("t4_done_latency", at, 32'd2);

        // 5: slave never acks
        @(posedge cpu_clk); #1;
        slave_en = 0;
        m0_req = 1; m0_addr = 32'h0000_0044; m0_we = 0;
`ifdef BUS_TIMEOUT_EN
        exp_q.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b1));
        @(posedge cpu_clk);
        wait_done(40, at, hi);
        check("t5_timeout_latency", at, 32'd17);
        check("t5_s_req_cycles", hi, 32'd16);
        m0_exp = 32'hFFFF_FFFF;
`else
        @(posedge cpu_clk);
        hi = 0; errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge cpu_clk);
            if (s_req) hi++;
            if (bus_err) errs++;
        end
        check("t5_s_req_held", hi, 32'd100);
        check("t5_no_bus_err", errs, 32'd0);
        #1;
        fixed_rdata = 32'h0A0A_0005;
        exp_q.push_back(mk(1'b0, 32'h0A0A_0005, 1'b0));
        slave_en = 1;
        @(posedge cpu_clk);
        wait_done(10, at, hi);
        m0_exp = 32'h0A0A_0005;
`endif

        // 6: s_ack while IDLE is ignored; req dropped during XFER
        @(posedge cpu_clk); #1;
        slave_en = 1; force_ack = 1; fixed_rdata = 32'h5555_AAAA;
        repeat (3) @(posedge cpu_clk);
        #1;
        check("t6_idle_ack_s_req", {31'd0, s_req}, 32'd0);
        check("t6_idle_ack_rdata", m0_rdata, m0_exp);
        force_ack = 0; ack_wait = 2;
        @(posedge cpu_clk); #1;
        m0_req = 1; m0_addr = 32'h0000_0080; m0_we = 0;
        exp_q.push_back(mk(1'b0, 32'h5555_AAAA, 1'b0));
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("t6_s_req", {31'd0, s_req}, 32'd1);
        m0_req = 0;
        wait_done(10, at, hi);
        check("t6_done_latency", at, 32'd3);

        repeat (3) @(posedge cpu_clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
